// File: rtl/reset_seq_pkg.sv
// Shared types and default timing for the reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        StWaitLock,
        StHold,
        StRelease,
        StRun
    } state_e;

    localparam int unsigned DefHoldCycles  = 16;
    localparam int unsigned DefGapCycles   = 4;
    localparam int unsigned DefPulseCycles = 8;

endpackage

// File: rtl/soft_pulse.sv
// One channel's soft-reset pulse timer: a request while idle in RUN starts a
// PULSE_CYCLES-long pulse that cannot be extended or restarted.
module soft_pulse
    import reset_seq_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES = DefPulseCycles
) (
    input  logic clk,
    input  logic enable,
    input  logic req,
    input  logic abort,
    output logic pulse_active
);

    localparam int unsigned TimerW = $clog2(PULSE_CYCLES) + 1;

    logic [TimerW-1:0] timer_q, timer_d;

    always_comb begin
        timer_d = '0;
        if (abort || !enable) begin
            timer_d = '0;
        end else if (timer_q != '0) begin
            if (timer_q < TimerW'(PULSE_CYCLES)) begin
                timer_d = timer_q + TimerW'(1);
            end
        end else if (req) begin
            timer_d = TimerW'(1);
        end
    end

    // Next-state view, so the channel flop falls on the same edge that samples req.
    assign pulse_active = (timer_d != '0);

    always_ff @(posedge clk) begin
        timer_q <= timer_d;
    end

endmodule

// File: rtl/reset_sequencer.sv
// Staggered release of NUM_CH downstream resets once lock has been stable,
// with per-channel soft-reset pulses while running.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned HOLD_CYCLES  = DefHoldCycles,
    parameter int unsigned GAP_CYCLES   = DefGapCycles,
    parameter int unsigned PULSE_CYCLES = DefPulseCycles
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              lock,
    input  logic [NUM_CH-1:0] soft_req,
    output logic [NUM_CH-1:0] ch_reset_n,
    output logic              all_released,
    output logic              busy
);

    localparam int unsigned CntMax = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax) + 1;
    localparam int unsigned IdxW   = $clog2(NUM_CH) + 1;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [NUM_CH-1:0] ch_q, ch_d, pulse_active;
    logic              all_rel_q, all_rel_d;
    logic              run, abort;

    assign run     = (state_q == StRun);
    assign abort   = reset | ~lock;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ch_d    = ch_q;
        case (state_q)
            StWaitLock: begin
                ch_d  = '0;
                cnt_d = '0;
                idx_d = '0;
                if (lock) state_d = StHold;
            end
            StHold: begin
                if (!lock) begin
                    state_d = StWaitLock;
                    ch_d    = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == CntW'(HOLD_CYCLES)) begin
                    ch_d[0] = 1'b1;
                    cnt_d   = '0;
                    idx_d   = IdxW'(1);
                    state_d = (NUM_CH == 1) ? StRun : StRelease;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StRelease: begin
                if (!lock) begin
                    state_d = StWaitLock;
                    ch_d    = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
                    for (int unsigned k = 0; k < NUM_CH; k++) begin
                        ch_d[k] = ch_q[k] | (idx_q == IdxW'(k));
                    end
                    cnt_d = '0;
                    idx_d = idx_q + IdxW'(1);
                    if (idx_q == IdxW'(NUM_CH - 1)) state_d = StRun;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StRun: begin
                if (!lock) begin
                    state_d = StWaitLock;
                    ch_d    = '0;
                end else begin
                    ch_d = ~pulse_active;
                end
            end
            default: state_d = StWaitLock;
        endcase
        all_rel_d = run && (state_d == StRun) && (&ch_d);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= StWaitLock;
            cnt_q     <= '0;
            idx_q     <= '0;
            all_rel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            all_rel_q <= all_rel_d;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        (* keep = "true" *) logic ch_bit_q;

        always_ff @(posedge CLOCK_50) begin
            if (reset) ch_bit_q <= 1'b0;
            else       ch_bit_q <= ch_d[k];
        end

        assign ch_q[k]       = ch_bit_q;
        assign ch_reset_n[k] = ch_bit_q;

        soft_pulse #(
            .PULSE_CYCLES(PULSE_CYCLES)
        ) u_soft_pulse (
            .clk         (CLOCK_50),
            .enable      (run),
            .req         (soft_req[k]),
            .abort       (abort),
            .pulse_active(pulse_active[k])
        );
    end

    assign all_released = all_rel_q;
    assign busy         = ~run;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: each driven cycle pushes the expected outputs for the edge
// that samples it; a monitor pops and compares just after that edge.
module tb_reset_sequencer;

    localparam int Hold = 16;
    localparam int Gap  = 4;

    typedef struct {
        logic [3:0] ch;
        logic       all;
        logic       busy;
        string      tag;
    } exp_t;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       lock     = 1'b0;
    logic [3:0] soft_req = 4'b0;
    logic [3:0] ch_reset_n;
    logic       all_released;
    logic       busy;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    reset_sequencer #(
        .NUM_CH      (4),
        .HOLD_CYCLES (16),
        .GAP_CYCLES  (4),
        .PULSE_CYCLES(8)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .lock        (lock),
        .soft_req    (soft_req),
        .ch_reset_n  (ch_reset_n),
        .all_released(all_released),
        .busy        (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected channel vector e edges after the sequence starts (lock held high).
    function automatic logic [3:0] seq_ch(input int e);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = (e >= 1 + Hold + k * Gap);
        return r;
    endfunction

    task automatic drive(input logic rst, input logic lk, input logic [3:0] req,
                         input logic [3:0] ch, input logic all, input logic bsy,
                         input string tag);
        exp_t x;
        @(negedge CLOCK_50);
        reset    = rst;
        lock     = lk;
        soft_req = req;
        x.ch = ch; x.all = all; x.busy = bsy; x.tag = tag;
        exp_q.push_back(x);
    endtask

    task automatic seq_step(input int e, input logic [3:0] req, input string tag);
        drive(1'b0, 1'b1, req, seq_ch(e), e >= 2 + Hold + 3 * Gap, e < 1 + Hold + 3 * Gap,
              $sformatf("%s@%0d", tag, e));
    endtask

    always begin
        @(posedge CLOCK_50);
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check_eq({mon_e.tag, "/ch"}, {4'b0, ch_reset_n}, {4'b0, mon_e.ch});
            check_eq({mon_e.tag, "/all"}, {7'b0, all_released}, {7'b0, mon_e.all});
            check_eq({mon_e.tag, "/busy"}, {7'b0, busy}, {7'b0, mon_e.busy});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Power-up
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 4'b0, 4'b0, 1'b0, 1'b1, "reset");
        for (int e = 0; e <= 32; e++) seq_step(e, 4'b0, "powerup");

        // Soft reset on channels 0 and 2
        drive(1'b0, 1'b1, 4'b0101, 4'b1010, 1'b0, 1'b0, "soft0");
        for (int j = 1; j < 8; j++)
            drive(1'b0, 1'b1, 4'b0, 4'b1010, 1'b0, 1'b0, $sformatf("soft%0d", j));
        drive(1'b0, 1'b1, 4'b0, 4'b1111, 1'b1, 1'b0, "soft_end");
        drive(1'b0, 1'b1, 4'b0, 4'b1111, 1'b1, 1'b0, "soft_idle");

        // Re-request during a pulse is ignored
        for (int j = 0; j < 10; j++)
            drive(1'b0, 1'b1, (j == 0 || j == 3) ? 4'b0010 : 4'b0,
                  (j < 8) ? 4'b1101 : 4'b1111, j >= 8, 1'b0, $sformatf("ignore%0d", j));

        // Held request: 8 low / 1 high
        for (int j = 0; j < 18; j++)
            drive(1'b0, 1'b1, 4'b0010, (j % 9 == 8) ? 4'b1111 : 4'b1101, j % 9 == 8, 1'b0,
                  $sformatf("held%0d", j));
        drive(1'b0, 1'b1, 4'b0, 4'b1111, 1'b1, 1'b0, "held_done0");
        drive(1'b0, 1'b1, 4'b0, 4'b1111, 1'b1, 1'b0, "held_done1");

        // Lock loss in RUN beats a same-edge request and cancels a live pulse
        drive(1'b0, 1'b1, 4'b0100, 4'b1011, 1'b0, 1'b0, "pre_loss");
        drive(1'b0, 1'b0, 4'b1000, 4'b0000, 1'b0, 1'b1, "lock_loss");
        for (int e = 0; e <= 33; e++) seq_step(e, (e < 20) ? 4'b1111 : 4'b0, "relock");

        // Late lock
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 4'b0, 4'b0, 1'b0, 1'b1, "reset2");
        for (int i = 0; i < 50; i++)
            drive(1'b0, 1'b0, 4'b0, 4'b0, 1'b0, 1'b1, $sformatf("nolock%0d", i));
        for (int e = 0; e <= 31; e++) seq_step(e, 4'b0, "late");

        // Lock glitch during release
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b1, 4'b0, 4'b0, 1'b0, 1'b1, "reset3");
        for (int e = 0; e <= 22; e++) seq_step(e, 4'b0, "glitch_pre");
        drive(1'b0, 1'b0, 4'b0, 4'b0, 1'b0, 1'b1, "glitch");
        for (int e = 0; e <= 31; e++) seq_step(e, 4'b0, "glitch_post");

        // Reset in the middle of a soft pulse
        drive(1'b0, 1'b1, 4'b0001, 4'b1110, 1'b0, 1'b0, "mid0");
        for (int j = 1; j < 4; j++)
            drive(1'b0, 1'b1, 4'b0, 4'b1110, 1'b0, 1'b0, $sformatf("mid%0d", j));
        drive(1'b1, 1'b1, 4'b0, 4'b0000, 1'b0, 1'b1, "rst_mid");
        for (int e = 0; e <= 36; e++) seq_step(e, 4'b0, "reseq");

        @(posedge CLOCK_50);
        #2;
        check_eq("drain", 8'(exp_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of downstream reset channels, legal range 1-8.
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 16: cycles `lock` must stay high before the first release, legal range >=1.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 4: cycles between successive channel releases, legal range >=1.
REQ-004 The block SHALL have parameter PULSE_CYCLES, default 8: soft-reset low time per channel, legal range >=1.
REQ-005 The block SHALL have port CLOCK_50, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high block reset.
REQ-007 The block SHALL have port lock, input, 1 bit: clock-source-stable indication, already synchronous to CLOCK_50.
REQ-008 The block SHALL have port soft_req, input, NUM_CH bits: per-channel soft reset request, level-sampled each cycle.
REQ-009 The block SHALL have port ch_reset_n, output, NUM_CH bits: per-channel active-low reset, each bit driven directly from its own flop.
REQ-010 The block SHALL have port all_released, output, 1 bit: high only when the state is RUN and every ch_reset_n bit is 1.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except RUN.

Function
REQ-012 The state machine SHALL have exactly the states WAIT_LOCK, HOLD, RELEASE and RUN.
REQ-013 In WAIT_LOCK, all ch_reset_n bits SHALL be 0, and the next edge with lock=1 SHALL enter HOLD with the hold counter at 0.
REQ-014 In HOLD, the counter SHALL increment while lock=1, and on reaching HOLD_CYCLES the state SHALL move to RELEASE with ch_reset_n[0] set to 1 at that edge.
REQ-015 In RELEASE, ch_reset_n[k] SHALL rise exactly GAP_CYCLES edges after ch_reset_n[k-1], for k = 1 to NUM_CH-1.
REQ-016 The edge that releases channel NUM_CH-1 SHALL enter RUN; with NUM_CH=1, the HOLD exit SHALL enter RUN directly.
REQ-017 Cycle budget: if reset deasserts at edge E0 and lock is held high, ch_reset_n[k] SHALL rise at E0+1+HOLD_CYCLES+k*GAP_CYCLES (defaults: 17, 21, 25, 29), and all_released SHALL rise at the next edge (30).
REQ-018 In HOLD or RELEASE, lock=0 sampled on an edge SHALL, at that same edge, drive all ch_reset_n to 0, clear all counters and enter WAIT_LOCK.
REQ-019 In RUN, lock=0 sampled on an edge SHALL, at that same edge, drive all ch_reset_n to 0, cancel all soft pulses and enter WAIT_LOCK; the full sequence then restarts from REQ-013.
REQ-020 In RUN, soft_req[i]=1 with channel i not pulsing SHALL drive ch_reset_n[i] to 0 at the next edge for exactly PULSE_CYCLES cycles, then back to 1.
REQ-021 soft_req[i] asserted while channel i is already pulsing SHALL be ignored: the pulse is neither extended nor restarted.
REQ-022 soft_req[i] held high SHALL retrigger a new pulse on the first edge after the previous pulse ends, giving one high cycle between pulses.
REQ-023 soft_req SHALL be ignored outside RUN.
REQ-024 Simultaneous requests on several channels SHALL be served independently and in parallel, with no arbitration.
REQ-025 lock loss SHALL take priority over soft_req on the same edge.
REQ-026 all_released SHALL drop at the same edge any ch_reset_n bit goes to 0.
REQ-027 Counters SHALL be sized with $clog2 of their limit plus 1, and SHALL saturate rather than wrap.

Reset
REQ-028 reset=1 sampled on an edge SHALL force state=WAIT_LOCK, ch_reset_n='0, all_released=0, busy=1, and all counters and soft-pulse timers to 0.
REQ-029 reset SHALL take priority over every other input, and asserting it mid-sequence or mid-pulse SHALL abort that sequence or pulse on the same edge.

Structure
REQ-030 Package reset_seq_pkg SHALL hold the state enum typedef and the default values of HOLD_CYCLES, GAP_CYCLES and PULSE_CYCLES.
REQ-031 A sub-module soft_pulse, instantiated NUM_CH times, SHALL own one channel's pulse timer, with inputs enable (RUN), req and abort and with output pulse_active.
REQ-032 The top level SHALL own the state machine, the hold/gap counter and the release index.
REQ-033 Each ch_reset_n bit SHALL be a distinct flop carrying a synthesis keep attribute, so that the tool does not merge them.

Verification
REQ-034 Power-up: reset high for 3 cycles, then low with lock=1 -> ch_reset_n rises at edges 17/21/25/29, all_released=1 at edge 30, busy=0 from edge 29.
REQ-035 Late lock: lock=0 for 50 cycles after reset -> outputs stay 0; ch_reset_n[0] rises 17 edges after lock rises.
REQ-036 Lock glitch: lock=0 for 1 cycle at edge 23 -> ch_reset_n[1:0] drop at edge 23, state WAIT_LOCK, full sequence restarts.
REQ-037 Soft reset: in RUN, soft_req=4'b0101 for 1 cycle -> ch_reset_n[0] and ch_reset_n[2] low for 8 cycles, all_released low for those 8 cycles, channels 1 and 3 unaffected.
REQ-038 Retrigger/ignore: soft_req[1] pulsed again 3 cycles into its pulse -> pulse still 8 cycles; soft_req[1] held high -> 8 low / 1 high repeating.
REQ-039 Reset mid-pulse: reset at pulse cycle 4 -> all ch_reset_n=0 the next edge, busy=1, no residual pulse after the resequence completes.
